// File: rtl/oversample_pkg.sv
// Shared bit/sample mapping for the 4x oversampled serial link (TX and RX sides).
package oversample_pkg;

    localparam int unsigned OS_FACTOR       = 4;
    localparam int unsigned SAMPLES_PER_CLK = 8;
    localparam int unsigned BITS_PER_CLK    = 2;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Two line bits leaving the frame queue in one clk; b0 goes on the wire first.
    typedef struct packed {
        logic b1;
        logic b0;
    } bit_pair_t;

    // Earlier bit lands in the upper nibble, matching OSERDES shift-out order.
    function automatic logic [SAMPLES_PER_CLK-1:0] os_expand(input logic b0, input logic b1);
        return {{OS_FACTOR{b0}}, {OS_FACTOR{b1}}};
    endfunction

endpackage

// File: rtl/os_frame_queue.sv
// Pending-bit queue: frames accepted words and releases two line bits per clock.
module os_frame_queue
    import oversample_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output bit_pair_t         pair_o,
    output logic              busy_o
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned Q_W     = FRAME_W + BITS_PER_CLK;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    logic [FRAME_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rdy_en_q;
    logic               busy_q;
    logic               accept;
    logic [FRAME_W-1:0] frame;
    logic [Q_W-1:0]     fill_mask;
    logic [Q_W-1:0]     stream;

    assign ready_o = rdy_en_q && (cnt_q <= CNT_W'(BITS_PER_CLK));
    assign accept  = valid_i && ready_o;
    assign frame   = {STOP_BIT, data_i, START_BIT};
    assign busy_o  = busy_q;
    assign pair_o  = '{b1: stream[1], b0: stream[0]};

    // Stream = pending bits, then the new frame (if any), then idle fill.
    always_comb begin
        fill_mask = ~((Q_W'(1) << cnt_q) - Q_W'(1));
        stream    = ({{BITS_PER_CLK{IDLE_BIT}}, pend_q} & ~fill_mask)
                  | ({Q_W{IDLE_BIT}} & fill_mask);
        if (accept) begin
            stream = (stream & ~(Q_W'({FRAME_W{1'b1}}) << cnt_q)) | (Q_W'(frame) << cnt_q);
        end
        pend_d = FRAME_W'(stream >> BITS_PER_CLK);

        if (accept) begin
            cnt_d = cnt_q + CNT_W'(FRAME_W - BITS_PER_CLK);
        end else if (cnt_q >= CNT_W'(BITS_PER_CLK)) begin
            cnt_d = cnt_q - CNT_W'(BITS_PER_CLK);
        end else begin
            cnt_d = '0;
        end
    end

    // rdy_en_q holds ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q   <= {FRAME_W{IDLE_BIT}};
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
            busy_q   <= (cnt_d != '0);
        end
    end

endmodule

// File: rtl/oversample_tx.sv
// UART-style framer emitting two 4x-oversampled bit periods per clock for an 8:1 serializer.
module oversample_tx
    import oversample_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          TX_INVERT = 1'b0
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [SAMPLES_PER_CLK-1:0] sample_window,
    output logic                       busy
);

    localparam logic [SAMPLES_PER_CLK-1:0] IDLE_WINDOW = {SAMPLES_PER_CLK{IDLE_BIT ^ TX_INVERT}};

    bit_pair_t                  pair;
    logic [SAMPLES_PER_CLK-1:0] window_d, window_q;

    os_frame_queue #(
        .DATA_W (DATA_W)
    ) u_queue (
        .clk     (clk),
        .aresetn (aresetn),
        .data_i  (s_data),
        .valid_i (s_valid),
        .ready_o (s_ready),
        .pair_o  (pair),
        .busy_o  (busy)
    );

    // Inversion compensates a P/N swap on the board.
    always_comb begin
        window_d = os_expand(pair.b0, pair.b1) ^ {SAMPLES_PER_CLK{TX_INVERT}};
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            window_q <= IDLE_WINDOW;
        end else begin
            window_q <= window_d;
        end
    end

    assign sample_window = window_q;

endmodule

// File: tb/tb_oversample_tx.sv
// Scoreboard bench for oversample_tx: three configurations checked against hand-computed windows.
module tb_oversample_tx;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_valid [3];
    logic [15:0] s_data  [3];
    logic        s_ready [3];
    logic [7:0]  win     [3];
    logic        busy    [3];

    always #5 clk = ~clk;

    oversample_tx #(.DATA_W(8), .TX_INVERT(1'b0)) u_dut8 (
        .clk(clk), .aresetn(aresetn), .s_data(s_data[0][7:0]), .s_valid(s_valid[0]),
        .s_ready(s_ready[0]), .sample_window(win[0]), .busy(busy[0]));

    oversample_tx #(.DATA_W(7), .TX_INVERT(1'b0)) u_dut7 (
        .clk(clk), .aresetn(aresetn), .s_data(s_data[1][6:0]), .s_valid(s_valid[1]),
        .s_ready(s_ready[1]), .sample_window(win[1]), .busy(busy[1]));

    oversample_tx #(.DATA_W(8), .TX_INVERT(1'b1)) u_dutinv (
        .clk(clk), .aresetn(aresetn), .s_data(s_data[2][7:0]), .s_valid(s_valid[2]),
        .s_ready(s_ready[2]), .sample_window(win[2]), .busy(busy[2]));

    typedef struct packed {
        logic [1:0] inst;
        logic       busy;
        logic       rdy;
        logic [7:0] win;
    } exp_t;

    exp_t        sb[$];
    logic [9:0]  vec_exp[$];
    logic [15:0] vec_words[$];
    int          errors = 0;
    int          checks = 0;
    int          mon_n  = 0;
    exp_t        mon_e;

    function automatic logic [9:0] ex(input logic b, input logic r, input logic [7:0] w);
        return {b, r, w};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got busy=%b ready=%b window=%h, expected busy=%b ready=%b window=%h",
                     name, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Monitor: one expected response per clock, compared away from the active edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check($sformatf("dut%0d_cycle%0d", mon_e.inst, mon_n),
                  {busy[mon_e.inst], s_ready[mon_e.inst], win[mon_e.inst]},
                  {mon_e.busy, mon_e.rdy, mon_e.win});
            mon_n++;
        end
    end

    // Driver: called at a negedge; offers vec_words, pushes vec_exp entries after each edge.
    task automatic run(input int inst);
        int wi = 0;
        for (int c = 0; c < vec_exp.size(); c++) begin
            logic acc;
            s_valid[inst] = (wi < vec_words.size());
            s_data[inst]  = (wi < vec_words.size()) ? vec_words[wi] : 16'h0;
            acc = s_valid[inst] && s_ready[inst];
            @(posedge clk);
            sb.push_back({2'(inst), vec_exp[c]});
            if (acc) wi++;
            @(negedge clk);
        end
        s_valid[inst] = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = 16'h0;
        end
        #12;
        check("reset_dut8",   {busy[0], s_ready[0], win[0]}, ex(1'b0, 1'b0, 8'hFF));
        check("reset_dut7",   {busy[1], s_ready[1], win[1]}, ex(1'b0, 1'b0, 8'hFF));
        check("reset_dutinv", {busy[2], s_ready[2], win[2]}, ex(1'b0, 1'b0, 8'h00));
        @(negedge clk);
        aresetn = 1'b1;

        // Idle line, ready from the first edge after release
        vec_words = {};
        vec_exp   = {};
        for (int i = 0; i < 20; i++) vec_exp.push_back(ex(1'b0, 1'b1, 8'hFF));
        run(0);

        // Single word A5
        vec_words = '{16'h00A5};
        vec_exp   = '{ex(1,0,8'h0F), ex(1,0,8'h0F), ex(1,0,8'h00), ex(1,1,8'hF0),
                      ex(0,1,8'hFF), ex(0,1,8'hFF)};
        run(0);

        // Back-to-back A5, 3C with no idle gap
        vec_words = '{16'h00A5, 16'h003C};
        vec_exp   = '{ex(1,0,8'h0F), ex(1,0,8'h0F), ex(1,0,8'h00), ex(1,1,8'hF0),
                      ex(1,0,8'hFF), ex(1,0,8'h00), ex(1,0,8'h0F), ex(1,0,8'hFF),
                      ex(1,1,8'hF0), ex(0,1,8'h0F), ex(0,1,8'hFF)};
        run(0);

        // DATA_W=7: odd frame packs stop bit and next start bit into one window
        vec_words = '{16'h007F, 16'h0000};
        vec_exp   = '{ex(1,0,8'h0F), ex(1,0,8'hFF), ex(1,0,8'hFF), ex(1,1,8'hFF),
                      ex(1,0,8'hF0), ex(1,0,8'h00), ex(1,0,8'h00), ex(1,1,8'h00),
                      ex(0,1,8'h0F), ex(0,1,8'hFF)};
        run(1);

        // Inverted line
        vec_words = '{16'h00A5};
        vec_exp   = '{ex(1,0,8'hF0), ex(1,0,8'hF0), ex(1,0,8'hFF), ex(1,1,8'h0F),
                      ex(0,1,8'h00), ex(0,1,8'h00)};
        run(2);

        // Reset mid-frame after the third window of A5
        vec_words = '{16'h00A5};
        vec_exp   = '{ex(1,0,8'h0F), ex(1,0,8'h0F), ex(1,0,8'h00)};
        run(0);
        #1 aresetn = 1'b0;
        #1;
        check("midreset_dut8",   {busy[0], s_ready[0], win[0]}, ex(1'b0, 1'b0, 8'hFF));
        check("midreset_dutinv", {busy[2], s_ready[2], win[2]}, ex(1'b0, 1'b0, 8'h00));
        @(negedge clk);
        aresetn = 1'b1;
        vec_words = '{16'h0001};
        vec_exp   = '{ex(0,1,8'hFF), ex(1,0,8'h0F), ex(1,0,8'h00), ex(1,0,8'h00),
                      ex(1,1,8'h00), ex(0,1,8'h0F), ex(0,1,8'hFF)};
        run(0);

        @(negedge clk);
        check("scoreboard_drained", 10'(sb.size()), 10'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
